vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 27 ++
 rtl/vram_wr_fifo.sv | 58 +++++
 rtl/vram_arbiter.sv | 118 +++++++++++
 tb/tb_vram_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants and scheduler state encoding for the VRAM arbiter slice.
package vram_pkg;

  localparam int VRAM_AW = 19;
  localparam int VRAM_DW = 36;
  localparam logic [10:0] H_ACTIVE = 11'd1024;
  localparam logic [9:0]  V_ACTIVE = 10'd768;

  typedef enum logic [1:0] {
    ACTIVE_DISP = 2'd0,
    ACTIVE_WR   = 2'd1,
    BLANK       = 2'd2
  } sched_state_t;

  // Classify the current pixel position into the slot type the ZBT port serves.
  function automatic sched_state_t slot_kind(input logic [10:0] hcount, input logic [9:0] vcount);
    sched_state_t kind;
    if (hcount >= H_ACTIVE || vcount >= V_ACTIVE)
      kind = BLANK;
    else if (hcount[1:0] == 2'd0)
      kind = ACTIVE_DISP;
    else
      kind = ACTIVE_WR;
    return kind;
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write-buffer FIFO holding {address, data} words for the VRAM arbiter.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = VRAM_AW + VRAM_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Time-slot arbiter sharing one ZBT port between display reads and buffered writes.
// Optional VRAM_ARB_STATS_EN adds a saturating write-stall cycle counter.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ZBT_LAT    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         hcount,
  input  logic [9:0]          vcount,
  input  logic [VRAM_AW-1:0]  disp_addr,
  output logic [VRAM_DW-1:0]  disp_data,
  output logic                disp_valid,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [VRAM_AW-1:0]  wr_addr,
  input  logic [VRAM_DW-1:0]  wr_data,
  output logic [VRAM_AW-1:0]  vram_addr,
  output logic                vram_we,
  output logic [VRAM_DW-1:0]  vram_write_data,
  input  logic [VRAM_DW-1:0]  vram_read_data,
  output logic                busy
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]         wr_stall_cnt
`endif
);

  sched_state_t                  slot;
  sched_state_t                  state;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [VRAM_AW+VRAM_DW-1:0]    head;
  logic                          push;
  logic                          pop;
  logic [VRAM_DW-1:0]            wd_pipe [ZBT_LAT+1];
  logic [ZBT_LAT-1:0]            we_sh;
  logic [ZBT_LAT-1:0]            rd_sh;

  assign slot     = slot_kind(hcount, vcount);
  assign wr_ready = !fifo_full;
  assign push     = wr_valid && wr_ready;
  assign pop      = (slot != ACTIVE_DISP) && !fifo_empty;

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (VRAM_AW + VRAM_DW)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Display slots always win the address bus; idle write slots leave the address parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BLANK;
      vram_addr <= '0;
      vram_we   <= 1'b0;
    end else begin
      state   <= slot;
      vram_we <= 1'b0;
      if (slot == ACTIVE_DISP) begin
        vram_addr <= disp_addr;
      end else if (pop) begin
        vram_addr <= head[VRAM_AW+VRAM_DW-1:VRAM_DW];
        vram_we   <= 1'b1;
      end
    end
  end

  // Write data and read tags ride shift pipelines aligned to the ZBT latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= ZBT_LAT; i++)
        wd_pipe[i] <= '0;
      we_sh      <= '0;
      rd_sh      <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      wd_pipe[0] <= pop ? head[VRAM_DW-1:0] : '0;
      for (int i = 1; i <= ZBT_LAT; i++)
        wd_pipe[i] <= wd_pipe[i-1];
      we_sh[0] <= pop;
      rd_sh[0] <= (state == ACTIVE_DISP);
      for (int i = 1; i < ZBT_LAT; i++) begin
        we_sh[i] <= we_sh[i-1];
        rd_sh[i] <= rd_sh[i-1];
      end
      disp_valid <= rd_sh[ZBT_LAT-1];
      if (rd_sh[ZBT_LAT-1])
        disp_data <= vram_read_data;
    end
  end

  assign vram_write_data = wd_pipe[ZBT_LAT];
  assign busy            = (fifo_count != '0) || (|we_sh);

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      wr_stall_cnt <= '0;
    else if (wr_valid && !wr_ready && wr_stall_cnt != 16'hFFFF)
      wr_stall_cnt <= wr_stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a two-cycle ZBT read model.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [18:0] disp_addr;
  logic [35:0] disp_data;
  logic        disp_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [35:0] wr_data;
  logic [18:0] vram_addr;
  logic        vram_we;
  logic [35:0] vram_write_data;
  logic [35:0] vram_read_data;
  logic        busy;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] wr_stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  vram_arbiter #(.FIFO_DEPTH(4), .ZBT_LAT(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .hcount          (hcount),
    .vcount          (vcount),
    .disp_addr       (disp_addr),
    .disp_data       (disp_data),
    .disp_valid      (disp_valid),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .vram_addr       (vram_addr),
    .vram_we         (vram_we),
    .vram_write_data (vram_write_data),
    .vram_read_data  (vram_read_data),
    .busy            (busy)
`ifdef VRAM_ARB_STATS_EN
    ,
    .wr_stall_cnt    (wr_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ZBT model: read data for an address appears two cycles after that address.
  logic [18:0] a1, a2;
  always @(posedge clk) begin
    a1 <= vram_addr;
    a2 <= a1;
  end

  function automatic logic [35:0] readModel(input logic [18:0] a);
    return (a == 19'h00123) ? 36'hABCDEF012 : ({17'h0, a} ^ 36'h5A5A5A5A5);
  endfunction

  assign vram_read_data = readModel(a2);

  function automatic logic [35:0] wdata(input logic [18:0] a);
    return 36'hC00000000 | {17'h0, a};
  endfunction

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [10:0] hc, input logic [9:0] vc, input logic [18:0] da,
                               input logic wv, input logic [18:0] wa);
    hcount    = hc;
    vcount    = vc;
    disp_addr = da;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wdata(wa);
  endtask

  task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [18:0] next_addr;
    int accepted;

    // Reset state
    reset = 1'b1;
    applyStimulus(11'd1030, 10'd0, 19'h0, 1'b0, 19'h0);
    stepClock();
    stepClock();
    checkOutput("rst_we", vram_we, 0);
    checkOutput("rst_addr", vram_addr, 0);
    checkOutput("rst_wdata", vram_write_data, 0);
    checkOutput("rst_ddata", disp_data, 0);
    checkOutput("rst_dvalid", disp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", wr_ready, 1);
    reset = 1'b0;
    stepClock();
    checkOutput("post_rst_ready", wr_ready, 1);

    // Display read, no writes
    applyStimulus(11'd0, 10'd10, 19'h00123, 1'b0, 19'h0);
    stepClock();
    checkOutput("disp_addr", vram_addr, 36'h00123);
    checkOutput("disp_we", vram_we, 0);
    applyStimulus(11'd1, 10'd10, 19'h7FFFF, 1'b0, 19'h0);
    stepClock();
    checkOutput("idle_hold_addr", vram_addr, 36'h00123);
    checkOutput("dvalid_early1", disp_valid, 0);
    applyStimulus(11'd2, 10'd10, 19'h7FFFF, 1'b0, 19'h0);
    stepClock();
    checkOutput("dvalid_early2", disp_valid, 0);
    applyStimulus(11'd1030, 10'd10, 19'h7FFFF, 1'b0, 19'h0);
    stepClock();
    checkOutput("dvalid", disp_valid, 1);
    checkOutput("ddata", disp_data, 36'hABCDEF012);

    // Three writes queued behind display slots, then issued in slots 1..3
    for (int i = 0; i < 3; i++) begin
      applyStimulus(11'd8, 10'd10, 19'h04444, 1'b1, 19'(19'h100 + i));
      stepClock();
    end
    checkOutput("queued_busy", busy, 1);
    checkOutput("queued_ready", wr_ready, 1);
    applyStimulus(11'd9, 10'd10, 19'h04444, 1'b0, 19'h0);
    stepClock();
    checkOutput("w1_addr", vram_addr, 36'h100);
    checkOutput("w1_we", vram_we, 1);
    applyStimulus(11'd10, 10'd10, 19'h04444, 1'b0, 19'h0);
    stepClock();
    checkOutput("w2_addr", vram_addr, 36'h101);
    applyStimulus(11'd11, 10'd10, 19'h04444, 1'b0, 19'h0);
    stepClock();
    checkOutput("w3_addr", vram_addr, 36'h102);
    checkOutput("w3_wdata", vram_write_data, wdata(19'h100));
    applyStimulus(11'd12, 10'd10, 19'h04444, 1'b0, 19'h0);
    stepClock();
    checkOutput("w4_disp_addr", vram_addr, 36'h04444);
    checkOutput("w4_we", vram_we, 0);
    checkOutput("w4_wdata", vram_write_data, wdata(19'h101));
    checkOutput("w4_busy", busy, 1);
    applyStimulus(11'd13, 10'd10, 19'h04444, 1'b0, 19'h0);
    stepClock();
    checkOutput("w5_wdata", vram_write_data, wdata(19'h102));
    checkOutput("w5_we", vram_we, 0);
    checkOutput("w5_busy", busy, 0);

    // Continuous writer during active video
    next_addr = 19'h200;
    accepted  = 0;
    for (int i = 0; i < 21; i++) begin
      applyStimulus(11'(16 + i), 10'd10, 19'h04444, 1'b1, next_addr);
      if (i == 12) checkOutput("ready_before_full", wr_ready, 1);
      if (i == 13) checkOutput("ready_full", wr_ready, 0);
      if (i >= 13 && wr_ready) accepted++;
      if (wr_ready) next_addr = next_addr + 19'd1;
      stepClock();
    end
    checkOutput("accept_rate", 36'(accepted), 36'd6);
    checkOutput("accepted_total", 36'(next_addr), 36'h213);
`ifdef VRAM_ARB_STATS_EN
    checkOutput("stall_cnt", 36'(wr_stall_cnt), 36'd2);
`endif

    // Blanking drain of a full FIFO
    for (int i = 0; i < 4; i++) begin
      applyStimulus(11'd1030, 10'd10, 19'h04444, 1'b0, 19'h0);
      stepClock();
      checkOutput("drain_addr", vram_addr, 36'(19'h20F + i));
      checkOutput("drain_we", vram_we, 1);
      if (i == 2) checkOutput("drain_wdata", vram_write_data, wdata(19'h20F));
    end
    stepClock();
    checkOutput("drain_tail_we", vram_we, 0);
    checkOutput("drain_tail_addr", vram_addr, 36'h212);
    checkOutput("drain_tail_busy", busy, 1);
    stepClock();
    checkOutput("drain_idle_busy", busy, 0);

    // Reset with two words queued and one in flight
    for (int i = 0; i < 3; i++) begin
      applyStimulus(11'd0, 10'd10, 19'h04444, 1'b1, 19'(19'h300 + i));
      stepClock();
    end
    applyStimulus(11'd1, 10'd10, 19'h04444, 1'b0, 19'h0);
    stepClock();
    checkOutput("inflight_addr", vram_addr, 36'h300);
    checkOutput("inflight_we", vram_we, 1);
    reset = 1'b1;
    applyStimulus(11'd2, 10'd10, 19'h04444, 1'b0, 19'h0);
    stepClock();
    checkOutput("midrst_we", vram_we, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", wr_ready, 1);
    checkOutput("midrst_addr", vram_addr, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(11'd1030, 10'd10, 19'h04444, 1'b0, 19'h0);
      stepClock();
      checkOutput("postrst_we", vram_we, 0);
      checkOutput("postrst_wdata", vram_write_data, 0);
    end

    // Vertical transition into blanking mid-burst
    for (int i = 0; i < 4; i++) begin
      applyStimulus(11'd1020, 10'd767, 19'h04444, 1'b1, 19'(19'h400 + i));
      stepClock();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(11'(1021 + i), 10'd767, 19'h04444, 1'b0, 19'h0);
      stepClock();
      checkOutput("vt_burst_addr", vram_addr, 36'(19'h400 + i));
    end
    applyStimulus(11'd0, 10'd768, 19'h04444, 1'b0, 19'h0);
    stepClock();
    checkOutput("vt_blank_addr", vram_addr, 36'h403);
    checkOutput("vt_blank_we", vram_we, 1);
    applyStimulus(11'd4, 10'd768, 19'h04444, 1'b0, 19'h0);
    stepClock();
    checkOutput("vt_no_disp_addr", vram_addr, 36'h403);
    checkOutput("vt_no_disp_we", vram_we, 0);
    applyStimulus(11'd8, 10'd768, 19'h04444, 1'b0, 19'h0);
    stepClock();
    checkOutput("vt_last_wdata", vram_write_data, wdata(19'h403));
    checkOutput("vt_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
